// File: rtl/tbird_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tbird_seq_ctrl
// Brief    : Parametrised Thunderbird tail-light sequencer with tick prescaler.
//            Optional TBIRD_IDLE_DIM_EN adds 1/8-duty idle running lights.
// Revision : 1.0 - initial release
// ============================================================================
module tbird_seq_ctrl #(
  parameter int LAMPS    = 3,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic             CLK100MHZ,
  input  logic             RST_N,
  input  logic             L,
  input  logic             R,
  input  logic             B,
  input  logic             HAZ,
  output logic [LAMPS-1:0] LEFT_LAMPS,
  output logic [LAMPS-1:0] RIGHT_LAMPS,
  output logic [1:0]       STATE
);

  localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int STEP_W = $clog2(LAMPS + 1);

  localparam logic [CNT_W-1:0]  c_CNT_MAX  = CNT_W'(TICK_DIV - 1);
  localparam logic [STEP_W-1:0] c_STEP_MAX = STEP_W'(LAMPS);
  localparam logic [STEP_W-1:0] c_STEP_ONE = STEP_W'(1);
  localparam logic [LAMPS-1:0]  c_ONES     = '1;

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_LEFT   = 2'd1;
  localparam logic [1:0] c_RIGHT  = 2'd2;
  localparam logic [1:0] c_HAZARD = 2'd3;

  logic [3:0]        r_sync_meta;
  logic [3:0]        r_sync;
  logic              w_l;
  logic              w_r;
  logic              w_b;
  logic              w_haz;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_tick;
  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [STEP_W-1:0] r_step;
  logic [STEP_W-1:0] w_step_nxt;
  logic [LAMPS-1:0]  w_therm;
  logic [LAMPS-1:0]  w_brake_lamps;
  logic [LAMPS-1:0]  w_idle_lamps;
  logic [LAMPS-1:0]  w_left_nxt;
  logic [LAMPS-1:0]  w_right_nxt;
  logic [LAMPS-1:0]  r_left;
  logic [LAMPS-1:0]  r_right;

  // Switch inputs are asynchronous; bit order {HAZ, B, R, L}.
  always_ff @(posedge CLK100MHZ or negedge RST_N) begin
    if (!RST_N) begin
      r_sync_meta <= '0;
      r_sync      <= '0;
    end else begin
      r_sync_meta <= {HAZ, B, R, L};
      r_sync      <= r_sync_meta;
    end
  end

  assign w_l   = r_sync[0];
  assign w_r   = r_sync[1];
  assign w_b   = r_sync[2];
  assign w_haz = r_sync[3];

  assign w_tick = (r_cnt == c_CNT_MAX);

  always_ff @(posedge CLK100MHZ or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    if (w_tick) begin
      if (r_step == '0) begin
        if (w_haz || (w_l && w_r)) begin
          w_state_nxt = c_HAZARD;
          w_step_nxt  = c_STEP_ONE;
        end else if (w_l) begin
          w_state_nxt = c_LEFT;
          w_step_nxt  = c_STEP_ONE;
        end else if (w_r) begin
          w_state_nxt = c_RIGHT;
          w_step_nxt  = c_STEP_ONE;
        end else begin
          w_state_nxt = c_IDLE;
          w_step_nxt  = '0;
        end
      end else if (w_haz && ((r_state == c_LEFT) || (r_state == c_RIGHT))) begin
        w_state_nxt = c_HAZARD;
        w_step_nxt  = c_STEP_ONE;
      end else begin
        case (r_state)
          c_LEFT, c_RIGHT: w_step_nxt = (r_step == c_STEP_MAX) ? '0 : r_step + c_STEP_ONE;
          // Hazard returns to its dark frame; idle never holds a non-zero step.
          default:         w_step_nxt = '0;
        endcase
      end
    end
  end

  always_ff @(posedge CLK100MHZ or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= c_IDLE;
      r_step  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LAMPS; gi++) begin : g_therm
      assign w_therm[gi] = (r_step > STEP_W'(gi));
    end
  endgenerate

  assign w_brake_lamps = w_b ? c_ONES : '0;

`ifdef TBIRD_IDLE_DIM_EN
  logic [2:0] r_pwm;

  always_ff @(posedge CLK100MHZ or negedge RST_N) begin
    if (!RST_N) begin
      r_pwm <= 3'd0;
    end else begin
      r_pwm <= r_pwm + 3'd1;
    end
  end

  assign w_idle_lamps = (w_b || (r_pwm == 3'd0)) ? c_ONES : '0;
`else
  assign w_idle_lamps = w_brake_lamps;
`endif

  always_comb begin
    w_left_nxt  = w_idle_lamps;
    w_right_nxt = w_idle_lamps;
    case (r_state)
      c_LEFT: begin
        w_left_nxt  = w_therm;
        w_right_nxt = w_brake_lamps;
      end
      c_RIGHT: begin
        w_left_nxt  = w_brake_lamps;
        w_right_nxt = w_therm;
      end
      c_HAZARD: begin
        w_left_nxt  = (r_step == c_STEP_ONE) ? c_ONES : '0;
        w_right_nxt = (r_step == c_STEP_ONE) ? c_ONES : '0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge RST_N) begin
    if (!RST_N) begin
      r_left  <= '0;
      r_right <= '0;
    end else begin
      r_left  <= w_left_nxt;
      r_right <= w_right_nxt;
    end
  end

  assign LEFT_LAMPS  = r_left;
  assign RIGHT_LAMPS = r_right;
  assign STATE       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_tbird_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tbird_seq_ctrl
// Brief    : Scoreboard bench for tbird_seq_ctrl (3-lamp/div-4 and 1-lamp/div-1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tbird_seq_ctrl;

  typedef struct {
    int         cyc;
    logic [7:0] l;
    logic [7:0] r;
    logic [1:0] st;
    string      name;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst_n, l, r, b, haz;
  logic [2:0] left1, right1;
  logic [1:0] st1;
  logic       rst2_n, l2, r2, b2, haz2;
  logic [0:0] left2, right2;
  logic [1:0] st2;

  int  cyc, cyc2;
  int  n_vec  = 0;
  int  n_miss = 0;
  sb_t q1[$];
  sb_t q2[$];

  always #5 clk = ~clk;

  tbird_seq_ctrl #(.LAMPS(3), .TICK_DIV(4)) dut (
    .CLK100MHZ(clk), .RST_N(rst_n), .L(l), .R(r), .B(b), .HAZ(haz),
    .LEFT_LAMPS(left1), .RIGHT_LAMPS(right1), .STATE(st1)
  );

  tbird_seq_ctrl #(.LAMPS(1), .TICK_DIV(1)) dut2 (
    .CLK100MHZ(clk), .RST_N(rst2_n), .L(l2), .R(r2), .B(b2), .HAZ(haz2),
    .LEFT_LAMPS(left2), .RIGHT_LAMPS(right2), .STATE(st2)
  );

  // Cycle numbers count posedges since reset release.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0; else cyc <= cyc + 1;
  always @(posedge clk or negedge rst2_n)
    if (!rst2_n) cyc2 <= 0; else cyc2 <= cyc2 + 1;

  task automatic score(input string nm, input int c, input bit on_time,
                       input logic [17:0] got, input logic [17:0] want);
    n_vec++;
    if (!on_time || got !== want) begin
      n_miss++;
      $display("FAIL %s @cyc %0d: got L=%b R=%b S=%0d, expected L=%b R=%b S=%0d",
               nm, c, got[17:10], got[9:2], got[1:0], want[17:10], want[9:2], want[1:0]);
    end
  endtask

  task automatic push1(input int c, input logic [2:0] el, input logic [2:0] er,
                       input logic [1:0] es, input string nm);
    sb_t e;
    e.cyc = c; e.l = {5'd0, el}; e.r = {5'd0, er}; e.st = es; e.name = nm;
    q1.push_back(e);
  endtask

  task automatic push2(input int c, input logic el, input logic er,
                       input logic [1:0] es, input string nm);
    sb_t e;
    e.cyc = c; e.l = {7'd0, el}; e.r = {7'd0, er}; e.st = es; e.name = nm;
    q2.push_back(e);
  endtask

  // Monitor: compares the queue head whenever its cycle comes up.
  always @(negedge clk) begin
    sb_t e;
    if (rst_n) begin
      while (q1.size() > 0 && q1[0].cyc <= cyc) begin
        e = q1.pop_front();
        score(e.name, cyc, e.cyc == cyc, {5'd0, left1, 5'd0, right1, st1}, {e.l, e.r, e.st});
      end
    end
    if (rst2_n) begin
      while (q2.size() > 0 && q2[0].cyc <= cyc2) begin
        e = q2.pop_front();
        score(e.name, cyc2, e.cyc == cyc2, {7'd0, left2, 7'd0, right2, st2}, {e.l, e.r, e.st});
      end
    end
  end

  task automatic wait_cyc1(input int n);
    int guard = 0;
    while (cyc != n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) score("wait_cyc1", cyc, 1'b0, 18'(cyc), 18'(n));
  endtask

  task automatic wait_cyc2(input int n);
    int guard = 0;
    while (cyc2 != n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc2 != n) score("wait_cyc2", cyc2, 1'b0, 18'(cyc2), 18'(n));
  endtask

  task automatic run_dut1();
    logic [2:0] pat  [4];
    logic [2:0] pat2 [6];
    pat  = '{3'b001, 3'b011, 3'b111, 3'b000};
    pat2 = '{3'b011, 3'b111, 3'b000, 3'b001, 3'b011, 3'b111};
    @(negedge clk);
    rst_n = 1'b1;
    push1(10, 3'b000, 3'b000, 2'd0, "idle");
    push1(20, 3'b000, 3'b000, 2'd0, "idle");
    push1(40, 3'b000, 3'b000, 2'd0, "idle");
    push1(44, 3'b000, 3'b000, 2'd1, "left_enter");
    for (int k = 0; k < 16; k++) push1(45 + k, pat[k/4], 3'b000, 2'd1, "left_seq");
    for (int k = 0; k < 4; k++)  push1(61 + k, 3'b001, 3'b000, 2'd1, "left_seq");
    for (int k = 0; k < 24; k++) push1(65 + k, pat2[k/4], 3'b111, 2'd1, "left_brake");
    for (int k = 0; k < 3; k++)  push1(89 + k, 3'b000, 3'b111, 2'd1, "left_dark");
    push1(92, 3'b000, 3'b111, 2'd0, "to_idle");
    for (int k = 0; k < 6; k++)  push1(93 + k, 3'b111, 3'b111, 2'd0, "idle_brake");
    push1(99, 3'b000, 3'b000, 2'd0, "brake_off");
    push1(100, 3'b000, 3'b000, 2'd0, "brake_off");
    wait_cyc1(41); l = 1'b1;
    wait_cyc1(62); b = 1'b1;
    wait_cyc1(82); l = 1'b0;
    wait_cyc1(96); b = 1'b0;

    for (int k = 0; k < 3; k++)  push1(101 + k, 3'b000, 3'b000, 2'd0, "pre_left");
    push1(104, 3'b000, 3'b000, 2'd1, "left_enter2");
    for (int k = 0; k < 4; k++)  push1(105 + k, 3'b001, 3'b000, 2'd1, "left_r_ignored");
    for (int k = 0; k < 3; k++)  push1(109 + k, 3'b011, 3'b000, 2'd1, "left_step2");
    push1(112, 3'b011, 3'b000, 2'd3, "haz_preempt");
    for (int k = 0; k < 20; k++)
      push1(113 + k, ((k/4) % 2 == 0) ? 3'b111 : 3'b000,
            ((k/4) % 2 == 0) ? 3'b111 : 3'b000, 2'd3, "haz_toggle");
    for (int k = 0; k < 3; k++)  push1(133 + k, 3'b000, 3'b000, 2'd3, "haz_dark");
    for (int k = 0; k < 5; k++)  push1(136 + k, 3'b000, 3'b000, 2'd0, "haz_exit");
    wait_cyc1(100); l = 1'b1;
    wait_cyc1(105); r = 1'b1;
    wait_cyc1(109); haz = 1'b1;
    wait_cyc1(129); l = 1'b0; r = 1'b0; haz = 1'b0;

    for (int k = 0; k < 3; k++)  push1(141 + k, 3'b000, 3'b000, 2'd0, "pre_lr");
    push1(144, 3'b000, 3'b000, 2'd3, "lr_hazard");
    for (int k = 0; k < 4; k++)  push1(145 + k, 3'b111, 3'b111, 2'd3, "lr_on");
    for (int k = 0; k < 4; k++)  push1(149 + k, 3'b000, 3'b000, 2'd3, "lr_off");
    push1(153, 3'b111, 3'b111, 2'd3, "lr_on");
    push1(154, 3'b111, 3'b111, 2'd3, "lr_on");
    wait_cyc1(141); l = 1'b1; r = 1'b1;
    wait_cyc1(154);
    #2 rst_n = 1'b0;
    #1 score("async_reset", cyc, 1'b1, {5'd0, left1, 5'd0, right1, st1}, 18'd0);
    r = 1'b0;
    // Restart checks: with the prescaler back at 0, L gives the first tick at cycle 4.
    for (int k = 1; k < 4; k++)  push1(k, 3'b000, 3'b000, 2'd0, "restart_idle");
    push1(4, 3'b000, 3'b000, 2'd1, "restart_left");
    for (int k = 0; k < 4; k++)  push1(5 + k, 3'b001, 3'b000, 2'd1, "restart_seq");
    for (int k = 0; k < 4; k++)  push1(9 + k, 3'b011, 3'b000, 2'd1, "restart_seq");
    repeat (3) @(negedge clk);
    score("reset_held", cyc, 1'b1, {5'd0, left1, 5'd0, right1, st1}, 18'd0);
    rst_n = 1'b1;
    wait_cyc1(13);
  endtask

  task automatic run_dut2();
    logic dim;
    @(negedge clk);
    rst2_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
`ifdef TBIRD_IDLE_DIM_EN
      dim = (k == 1) || (k == 9);
`else
      dim = 1'b0;
`endif
      push2(k, dim, dim, 2'd0, "d1_idle");
    end
    push2(13, 1'b0, 1'b0, 2'd1, "d1_left_enter");
    for (int k = 14; k < 30; k++) push2(k, (k % 2) == 0, 1'b0, 2'd1, "d1_left_alt");
    wait_cyc2(10); l2 = 1'b1;
    wait_cyc2(30);
  endtask

  initial begin
    rst_n = 1'b0; l = 1'b0; r = 1'b0; b = 1'b0; haz = 1'b0;
    rst2_n = 1'b0; l2 = 1'b0; r2 = 1'b0; b2 = 1'b0; haz2 = 1'b0;
    repeat (2) @(negedge clk);
    score("reset_state", 0, 1'b1, {5'd0, left1, 5'd0, right1, st1}, 18'd0);
    fork
      run_dut1();
      run_dut2();
    join
    @(negedge clk);
    score("sb_drained", cyc, 1'b1, 18'(q1.size() + q2.size()), 18'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
